uart_loaded_visitor_counter: RTL and testbench

Top-level block of the automated visitor counter.
- An 8N1 UART receiver takes a program image byte by byte, packs it into 32-bit words and stores them in an internal instruction memory.
- write_done is raised once the terminator word arrives.
- After that, a hardware visitor counter runs on the two GPIO inputs and drives the count onto the eight GPIO outputs.

---
 rtl/uart_loaded_visitor_counter.sv | 168 ++++++++++++++++
 tb/tb_uart_loaded_visitor_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loaded_visitor_counter.sv
// Visitor counter top level. A UART receiver loads a program image into an
// internal instruction memory; once the terminator word arrives, a hardware
// visitor counter runs on the GPIO inputs and drives the count out.
//
// state | meaning
// IDLE  | line idle, waiting for a start-bit falling edge
// START | half a bit into the start bit, confirming it is not a glitch
// DATA  | sampling eight data bits LSB first at mid-bit
// STOP  | sampling the stop bit; decides valid / break / framing drop
module uart_loaded_visitor_counter #(
  parameter int          CLK_HZ       = 50000000,
  parameter int          BIT_RATE     = 9600,
  parameter int          CLKS_PER_BIT = CLK_HZ / BIT_RATE,
  parameter int          MEM_DEPTH    = 256,
  parameter logic [31:0] TERMINATOR   = 32'hFFFFFFFF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  output logic       uart_rx_break,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data,
  input  logic [1:0] input_gpio_pins,
  output logic [7:0] output_gpio_pins,
  output logic       write_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(MEM_DEPTH + 1);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rxd_meta, rxd_sync;
  logic [1:0]    gpio_meta, gpio_sync;
  logic          sensor_prev;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [AW-1:0] addr;
  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   full_word;
  logic          word_done;
  logic          mem_we;

  // Two-flop synchronisers; rxd idles high so it resets to 1
  always_ff @(posedge clk) begin
    if (resetn) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      gpio_meta <= 2'b00;
      gpio_sync <= 2'b00;
    end else begin
      rxd_meta  <= uart_rxd;
      rxd_sync  <= rxd_meta;
      gpio_meta <= input_gpio_pins;
      gpio_sync <= gpio_meta;
    end
  end

  // UART receive FSM with a down-counting bit timer
  always_ff @(posedge clk) begin
    if (resetn) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      case (state)
        IDLE: begin
          if (uart_rx_en && !rxd_sync) begin
            state   <= START;
            bit_cnt <= HALF_BIT;
          end
        end
        START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (!rxd_sync) begin
            state   <= DATA;
            bit_cnt <= FULL_BIT;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_cnt <= FULL_BIT;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            if (rxd_sync) begin
              uart_rx_data  <= shreg;
              uart_rx_valid <= 1'b1;
            end else if (shreg == 8'h00) begin
              uart_rx_break <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The fourth byte of a word completes it together with the three buffered ones
  assign full_word = {uart_rx_data, word_buf};
  assign word_done = uart_rx_valid && !write_done && (byte_idx == 2'd3);
  assign mem_we    = word_done && (full_word != TERMINATOR) && (addr < AW'(MEM_DEPTH));

  // Loader: pack little-endian bytes into words, detect terminator, saturate address
  always_ff @(posedge clk) begin
    if (resetn) begin
      write_done <= 1'b0;
      byte_idx   <= '0;
      word_buf   <= '0;
      addr       <= '0;
    end else if (uart_rx_valid && !write_done) begin
      byte_idx <= byte_idx + 1'b1;
      if (byte_idx != 2'd3) begin
        word_buf <= {uart_rx_data, word_buf[23:8]};
      end else if (full_word == TERMINATOR) begin
        write_done <= 1'b1;
      end else if (mem_we) begin
        addr <= addr + 1'b1;
      end
    end
  end

  // Instruction memory write port; contents need no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr[IW-1:0]] <= full_word;
  end

  // Visitor counter: armed rising edges of the sensor, only after loading
  always_ff @(posedge clk) begin
    if (resetn) begin
      sensor_prev      <= 1'b0;
      output_gpio_pins <= '0;
    end else begin
      sensor_prev <= gpio_sync[1];
      if (!write_done) output_gpio_pins <= '0;
      else if (gpio_sync[1] && !sensor_prev && gpio_sync[0])
        output_gpio_pins <= output_gpio_pins + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_loaded_visitor_counter.sv
// Bench for uart_loaded_visitor_counter: UART frames, break, loader and counter.
module tb_uart_loaded_visitor_counter;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_break, uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic [1:0] input_gpio_pins = 2'b00;
  logic [7:0] output_gpio_pins;
  logic       write_done;

  int tests = 0, fails = 0;
  int valid_cnt = 0, break_cnt = 0;
  logic [7:0] exp_q [$];

  uart_loaded_visitor_counter #(.CLKS_PER_BIT(C), .MEM_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .uart_rx_break(uart_rx_break), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .input_gpio_pins(input_gpio_pins),
    .output_gpio_pins(output_gpio_pins), .write_done(write_done));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each received byte is matched against the oldest expectation
  always @(negedge clk) begin
    if (uart_rx_break) break_cnt++;
    if (uart_rx_valid) begin
      valid_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h expected none", uart_rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (uart_rx_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %h expected %h", uart_rx_data, e);
        end
      end
    end
  end

  task automatic bit_time(input logic v);
    uart_rxd = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse();
    input_gpio_pins[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    input_gpio_pins[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       en;
    logic       exp_valid;
    logic       exp_break;
  } vec_t;

  vec_t vecs [7];
  logic [31:0] words [5];

  initial begin
    vecs[0] = '{8'h13, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h77, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    words[0] = 32'hF9010113; words[1] = 32'h06812623; words[2] = 32'h12345678;
    words[3] = 32'hCAFEF00D; words[4] = 32'hDEADBEEF;

    repeat (200) @(posedge clk);
    #1;
    check("rst_valid", uart_rx_valid, 0);
    check("rst_out", output_gpio_pins, 0);
    resetn = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    check("idle_data", uart_rx_data, 0);
    check("idle_break", uart_rx_break, 0);
    check("idle_wd", write_done, 0);
    check("idle_out", output_gpio_pins, 0);

    // Pre-load: pulses must not count
    input_gpio_pins[0] = 1'b1;
    for (int i = 0; i < 3; i++) pulse();
    check("preload_out", output_gpio_pins, 0);

    // Table-driven frame vectors
    begin
      logic [7:0] last_good;
      last_good = 8'h00;
      foreach (vecs[i]) begin
        int v0, b0;
        v0 = valid_cnt;
        b0 = break_cnt;
        uart_rx_en = vecs[i].en;
        if (vecs[i].exp_valid) begin
          exp_q.push_back(vecs[i].b);
          last_good = vecs[i].b;
        end
        send_frame(vecs[i].b, vecs[i].stop);
        uart_rx_en = 1'b1;
        check($sformatf("vec%0d_valid", i), valid_cnt - v0, {31'd0, vecs[i].exp_valid});
        check($sformatf("vec%0d_break", i), break_cnt - b0, {31'd0, vecs[i].exp_break});
        check($sformatf("vec%0d_data", i), uart_rx_data, last_good);
      end
    end

    // Dropping the enable mid-frame must not abort the frame
    exp_q.push_back(8'h3C);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (3 * C) @(posedge clk);
        #1;
        uart_rx_en = 1'b0;
      end
    join
    uart_rx_en = 1'b1;
    check("en_drop_data", uart_rx_data, 8'h3C);

    // Reset mid-frame discards the frame and the partial word
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (3 * C) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
      end
    join
    check("midrst_data", uart_rx_data, 0);
    check("midrst_idx", dut.byte_idx, 0);
    check("midrst_sb", exp_q.size(), 0);

    // Load five words into a four-word memory, then the terminator
    foreach (words[i]) send_word(words[i]);
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    check("wd_before_last", write_done, 0);
    send_byte(8'hFF);
    check("wd_after_last", write_done, 1);
    for (int i = 0; i < 4; i++) check($sformatf("mem%0d", i), dut.mem[i], words[i]);
    check("addr_sat", dut.addr, 4);
    check("out_after_load", output_gpio_pins, 0);

    // Second terminator after load: bytes reported, nothing changes
    send_word(32'hFFFFFFFF);
    check("wd_second", write_done, 1);
    check("addr_second", dut.addr, 4);
    check("mem0_second", dut.mem[0], words[0]);

    // Counting
    input_gpio_pins[0] = 1'b1;
    for (int i = 0; i < 3; i++) pulse();
    check("count3", output_gpio_pins, 3);
    input_gpio_pins[0] = 1'b0;
    for (int i = 0; i < 2; i++) pulse();
    check("disarmed", output_gpio_pins, 3);
    input_gpio_pins[0] = 1'b1;
    for (int i = 0; i < 252; i++) pulse();
    check("count255", output_gpio_pins, 255);
    pulse();
    check("wrap0", output_gpio_pins, 0);
    input_gpio_pins[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("level_no_count", output_gpio_pins, 1);
    input_gpio_pins[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends with a summary
  initial begin
    #5ms;
    fails++;
    $display("FAIL timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
